// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants for the 5-stage datapath.
package cpu_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD  = 32'hFC00_0000;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/next_pc_select.sv
// Next-PC priority mux (branch > jump > stall > PC+4) with target alignment and fault detect.
module next_pc_select
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_taken_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        redirect_o,
  output logic        fault_o
);

  localparam logic [32:0] ImemBytes = 33'(IMEM_WORDS) << 2;

  logic [31:0] target;
  logic        out_of_range;

  always_comb begin
    target     = '0;
    redirect_o = 1'b0;
    pc_plus4_o = pc_i + 32'(WORD_BYTES);
    next_pc_o  = pc_plus4_o;
    if (branch_taken_i) begin
      target     = branch_target_i;
      redirect_o = 1'b1;
    end else if (jump_taken_i) begin
      target     = jump_target_i;
      redirect_o = 1'b1;
    end
    if (redirect_o) begin
      next_pc_o = {target[31:2], 2'b00};
    end else if (stall_i) begin
      next_pc_o = pc_i;
    end
  end

  assign out_of_range = {1'b0, pc_i} >= ImemBytes;
  assign fault_o      = out_of_range | (redirect_o & (target[1:0] != 2'b00));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, BOOT/RUN/HALT control and the IF/ID pipeline register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter logic [31:0] HALT_WORD  = cpu_pkg::HALT_WORD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jumpTaken,
  input  logic [31:0] jumpTarget,
  output logic [31:0] programCounterOut,
  input  logic [31:0] instructionIn,
  output logic [31:0] ifidInstruction,
  output logic [31:0] ifidPCPlus4,
  output logic        ifidValid,
  output logic        halted,
  output logic        fetchFault
);
  import cpu_pkg::*;

  fetch_state_t state_d, state_q;
  ifid_t        ifid_d, ifid_q;
  logic [31:0]  pc_d, pc_q;
  logic         fault_d, fault_q;

  logic [31:0] sel_next_pc;
  logic [31:0] sel_pc_plus4;
  logic        sel_redirect;
  logic        sel_fault;

  next_pc_select #(
    .IMEM_WORDS(IMEM_WORDS)
  ) u_next_pc_select (
    .pc_i           (pc_q),
    .stall_i        (stall),
    .branch_taken_i (branchTaken),
    .branch_target_i(branchTarget),
    .jump_taken_i   (jumpTaken),
    .jump_target_i  (jumpTarget),
    .next_pc_o      (sel_next_pc),
    .pc_plus4_o     (sel_pc_plus4),
    .redirect_o     (sel_redirect),
    .fault_o        (sel_fault)
  );

  always_comb begin
    state_d = state_q;
    ifid_d  = ifid_q;
    pc_d    = pc_q;
    fault_d = fault_q | sel_fault;
    // A redirect is older than anything in fetch, so it wins in every state and over stall.
    if (sel_redirect) begin
      pc_d    = sel_next_pc;
      ifid_d  = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        BOOT: begin
          ifid_d  = '0;
          state_d = RUN;
        end
        RUN: begin
          if (!stall) begin
            ifid_d = '{instr: instructionIn, pcPlus4: sel_pc_plus4, valid: 1'b1};
            if (instructionIn == HALT_WORD) begin
              state_d = HALT;
            end else begin
              pc_d = sel_next_pc;
            end
          end
        end
        HALT: begin
          ifid_d = '0;
        end
        default: begin
          state_d = BOOT;
          ifid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= BOOT;
      ifid_q  <= '0;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ifid_q  <= ifid_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign programCounterOut = pc_q;
  assign ifidInstruction   = ifid_q.instr;
  assign ifidPCPlus4       = ifid_q.pcPlus4;
  assign ifidValid         = ifid_q.valid;
  assign halted            = (state_q == HALT);
  assign fetchFault        = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 1024-word combinational instruction memory.
module tb_instruction_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jumpTaken;
  logic [31:0] jumpTarget;
  logic [31:0] programCounterOut;
  logic [31:0] instructionIn;
  logic [31:0] ifidInstruction;
  logic [31:0] ifidPCPlus4;
  logic        ifidValid;
  logic        halted;
  logic        fetchFault;

  logic [31:0] mem [1024];

  int unsigned n_checks;
  int unsigned n_pass;

  instruction_fetch_unit dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .stall            (stall),
    .branchTaken      (branchTaken),
    .branchTarget     (branchTarget),
    .jumpTaken        (jumpTaken),
    .jumpTarget       (jumpTarget),
    .programCounterOut(programCounterOut),
    .instructionIn    (instructionIn),
    .ifidInstruction  (ifidInstruction),
    .ifidPCPlus4      (ifidPCPlus4),
    .ifidValid        (ifidValid),
    .halted           (halted),
    .fetchFault       (fetchFault)
  );

  assign instructionIn = mem[programCounterOut[11:2]];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] p4,
                            input logic valid, input logic [31:0] pc);
    check_eq({tag, ".instr"}, ifidInstruction, instr);
    check_eq({tag, ".pc4"}, ifidPCPlus4, p4);
    check_eq({tag, ".valid"}, 32'(ifidValid), 32'(valid));
    check_eq({tag, ".pc"}, programCounterOut, pc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".pc"}, programCounterOut, 32'h0);
    check_eq({tag, ".instr"}, ifidInstruction, 32'h0);
    check_eq({tag, ".pc4"}, ifidPCPlus4, 32'h0);
    check_eq({tag, ".valid"}, 32'(ifidValid), 32'h0);
    check_eq({tag, ".halted"}, 32'(halted), 32'h0);
    check_eq({tag, ".fault"}, 32'(fetchFault), 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h2000_0000 | 32'(i);
    mem[5] = 32'hFC00_0000;

    Reset        = 1'b0;
    stall        = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = '0;
    jumpTaken    = 1'b0;
    jumpTarget   = '0;
    #13;
    check_reset_outputs("reset");
    @(negedge Clk);
    Reset = 1'b1;

    // BOOT bubble, then straight-line fetch
    step();
    check_ifid("boot", 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    check_ifid("seq0", mem[0], 32'd4, 1'b1, 32'd4);
    step();
    check_ifid("seq1", mem[1], 32'd8, 1'b1, 32'd8);
    step();
    check_ifid("seq2", mem[2], 32'd12, 1'b1, 32'd12);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid("stall", mem[2], 32'd12, 1'b1, 32'd12);
    end
    stall = 1'b0;
    step();
    check_ifid("resume", mem[3], 32'd16, 1'b1, 32'd16);
    step();
    check_ifid("seq4", mem[4], 32'd20, 1'b1, 32'd20);

    // mem[5] holds the halt word
    step();
    check_ifid("haltw", 32'hFC00_0000, 32'd24, 1'b1, 32'h14);
    check_eq("halt.halted", 32'(halted), 32'h1);
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("halted.valid", 32'(ifidValid), 32'h0);
      check_eq("halted.pc", programCounterOut, 32'h14);
      check_eq("halted.halted", 32'(halted), 32'h1);
    end

    branchTaken  = 1'b1;
    branchTarget = 32'h0;
    step();
    branchTaken = 1'b0;
    check_ifid("unhalt", 32'h0, 32'h0, 1'b0, 32'h0);
    check_eq("unhalt.halted", 32'(halted), 32'h0);
    step();
    check_ifid("rerun", mem[0], 32'd4, 1'b1, 32'd4);

    branchTaken  = 1'b1;
    branchTarget = 32'h40;
    step();
    branchTaken = 1'b0;
    check_ifid("br40", 32'h0, 32'h0, 1'b0, 32'h40);
    step();
    check_ifid("br40f", mem[16], 32'h44, 1'b1, 32'h44);

    // Branch beats jump and stall
    branchTaken  = 1'b1;
    branchTarget = 32'h40;
    jumpTaken    = 1'b1;
    jumpTarget   = 32'h80;
    stall        = 1'b1;
    step();
    branchTaken = 1'b0;
    jumpTaken   = 1'b0;
    stall       = 1'b0;
    check_ifid("prio", 32'h0, 32'h0, 1'b0, 32'h40);
    check_eq("prio.fault", 32'(fetchFault), 32'h0);
    step();
    check_ifid("prio.f", mem[16], 32'h44, 1'b1, 32'h44);

    jumpTaken  = 1'b1;
    jumpTarget = 32'h1002;
    step();
    jumpTaken = 1'b0;
    check_ifid("jmis", 32'h0, 32'h0, 1'b0, 32'h1000);
    check_eq("jmis.fault", 32'(fetchFault), 32'h1);
    step();
    check_ifid("wrapidx", mem[0], 32'h1004, 1'b1, 32'h1004);
    check_eq("wrapidx.fault", 32'(fetchFault), 32'h1);

    branchTaken  = 1'b1;
    branchTarget = 32'hFFFF_FFFC;
    step();
    branchTaken = 1'b0;
    check_eq("top.pc", programCounterOut, 32'hFFFF_FFFC);
    step();
    check_ifid("pcwrap", mem[1023], 32'h0, 1'b1, 32'h0);
    check_eq("pcwrap.fault", 32'(fetchFault), 32'h1);
    step();

    // Asynchronous reset between edges
    #2;
    Reset = 1'b0;
    #1;
    check_reset_outputs("areset");
    @(negedge Clk);
    Reset = 1'b1;
    step();
    check_ifid("reboot", 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    check_ifid("reseq0", mem[0], 32'd4, 1'b1, 32'd4);
    check_eq("reseq0.fault", 32'(fetchFault), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
